irq_dispatch_seq: RTL and testbench
===================================

Name: irq_dispatch_seq

Overview:
- Interrupt dispatch sequencer for the SM83 core.
- At an instruction boundary with IME set and a pending enabled interrupt, it drives the register-file 16-bit port and the memory write bus through the dispatch sequence:
  - latch PC;
  - push PC onto the stack (high byte first);
  - load the vector into PC;
  - clear the serviced IF bit.
- It sits beside the decoder and owns the register-file rr port and the bus write port while busy.

Parameters:
- NUM_IRQ, 5, number of interrupt sources (VBlank, STAT, Timer, Serial, Joypad).
- VEC_BASE, 16'h0040, vector address of source 0.
- VEC_STEP, 8, vector spacing in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ime  in  1  interrupt master enable
- instr_boundary  in  1  core is at an opcode-fetch boundary and may be preempted
- ie_reg  in  NUM_IRQ  IE register
- if_reg  in  NUM_IRQ  IF register
- busy  out  1  dispatch in progress; decoder must not drive the rf rr or bus ports
- ime_clear  out  1  one-cycle pulse; clears IME
- if_clear  out  NUM_IRQ  one-hot, one-cycle pulse; clears the serviced IF bit
- done  out  1  one-cycle pulse in the final state
- rf_read_rr  out  1  register-file 16-bit read enable
- rf_read_reg_rr  out  register_nn_t  read select (SP or PC only)
- rf_data_rr  in  16  register-file 16-bit read data (combinational)
- rf_write_rr  out  1  register-file 16-bit write enable
- rf_write_reg_rr  out  register_nn_t  write select (SP or PC only)
- rf_data_in_rr  out  16  register-file 16-bit write data
- mem_wr_req  out  1  bus write request
- mem_addr  out  16  bus address
- mem_wdata  out  8  bus write data
- mem_ack  in  1  bus write accepted this cycle

Behaviour:
- Reset values: all outputs 0; selects = SP; state IDLE; internal pc_q, sp_q, idx_q = 0.
- Definitions:
  - pend = ie_reg & if_reg.
  - idx = lowest set bit of pend; bit 0 has highest priority.
- IDLE:
  - busy = 0.
  - If ime && instr_boundary && pend != 0: idx_q <= idx, go to LATCH_PC.
- LATCH_PC (1 cycle):
  - busy = 1; ime_clear = 1.
  - Read PC; pc_q <= rf_data_rr. Go to DEC_SP.
- DEC_SP (1 cycle):
  - Read SP; write SP = rf_data_rr - 1, mod 2^16 (0x0000 wraps to 0xFFFF).
  - sp_q <= rf_data_rr - 1. Go to PUSH_HI.
- PUSH_HI:
  - mem_wr_req = 1, mem_addr = sp_q, mem_wdata = pc_q[15:8].
  - Address and data are held stable until mem_ack.
  - On mem_ack:
    - Write SP = sp_q - 1; sp_q <= sp_q - 1.
    - Re-sample pend: if pend == 0, cancel_q <= 1; else idx_q <= idx. This handles a late IE write or a higher-priority arrival.
    - Go to PUSH_LO.
- PUSH_LO:
  - mem_wr_req = 1, mem_addr = sp_q, mem_wdata = pc_q[7:0].
  - On mem_ack, go to VECTOR.
- VECTOR (1 cycle):
  - Write PC = cancel_q ? 16'h0000 : VEC_BASE + VEC_STEP*idx_q.
  - if_clear = cancel_q ? 0 : one-hot(idx_q); done = 1.
  - Clear cancel_q. Go to IDLE.
- Latency: minimum 5 cycles from the IDLE detect edge to done when mem_ack is returned in the first request cycle. Each wait cycle adds 1.
- Port exclusivity: rf_read_rr and rf_write_rr are asserted only in the states listed above. Both are 0 in IDLE.
- Busy-time inputs:
  - ime deassertion while busy is ignored.
  - instr_boundary is ignored while not in IDLE.
  - New pend bits are ignored except at the PUSH_HI ack re-sample.
- mem_ack while mem_wr_req = 0 is ignored.
- Reset mid-operation:
  - Immediate return to IDLE; no pulses in the cycle after reset.
  - Partial SP or stack writes are not rolled back.
- Back-to-back dispatch: after VECTOR, a new dispatch may start on the very next IDLE cycle if its conditions hold.

Test Plan:
- Basic dispatch:
  - Stimulus: PC=0x1234, SP=0xFFFE, ie=5'h1F, if=5'b00100, ime=1, boundary=1, immediate ack.
  - Response: writes [0xFFFD]=0x12, then [0xFFFC]=0x34. SP ends 0xFFFC, PC=0x0050, if_clear=5'b00100, ime_clear pulses once, done on cycle 5.
- Priority:
  - Stimulus: if=5'b10110, ie=5'h1F.
  - Response: PC=0x0048, if_clear=5'b00010.
- Cancel:
  - Stimulus: ie drops to 0 before the PUSH_HI ack.
  - Response: PC=0x0000, if_clear=0, both pushes still occur.
- Bus wait states:
  - Stimulus: mem_ack delayed 3 cycles on each push.
  - Response: addr and wdata held constant while waiting; done on cycle 11; exactly 2 accepted writes.
- SP wrap:
  - Stimulus: SP=0x0000.
  - Response: writes to 0xFFFF and 0xFFFE; SP ends 0xFFFE.
- Mid-operation reset:
  - Stimulus: rst in PUSH_LO.
  - Response: next cycle all outputs 0 and state IDLE. With ime=0, or instr_boundary=0, or pend=0: busy stays 0 indefinitely.

Source files
------------

// File: rtl/irq_dispatch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_dispatch_seq : SM83 interrupt dispatch (push PC, jump to vector)  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

package irq_dispatch_pkg;
    typedef enum logic [2:0] {
        REG_BC = 3'd0,
        REG_DE = 3'd1,
        REG_HL = 3'd2,
        REG_SP = 3'd3,
        REG_AF = 3'd4,
        REG_PC = 3'd5
    } register_nn_t;
endpackage

module irq_dispatch_seq
    import irq_dispatch_pkg::*;
#(
    parameter int          NUM_IRQ  = 5,
    parameter logic [15:0] VEC_BASE = 16'h0040,
    parameter int unsigned VEC_STEP = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ime,
    input  logic               instr_boundary,
    input  logic [NUM_IRQ-1:0] ie_reg,
    input  logic [NUM_IRQ-1:0] if_reg,
    output logic               busy,
    output logic               ime_clear,
    output logic [NUM_IRQ-1:0] if_clear,
    output logic               done,
    output logic               rf_read_rr,
    output register_nn_t       rf_read_reg_rr,
    input  logic [15:0]        rf_data_rr,
    output logic               rf_write_rr,
    output register_nn_t       rf_write_reg_rr,
    output logic [15:0]        rf_data_in_rr,
    output logic               mem_wr_req,
    output logic [15:0]        mem_addr,
    output logic [7:0]         mem_wdata,
    input  logic               mem_ack
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LATCH_PC = 3'd1;
    localparam logic [2:0] S_DEC_SP   = 3'd2;
    localparam logic [2:0] S_PUSH_HI  = 3'd3;
    localparam logic [2:0] S_PUSH_LO  = 3'd4;
    localparam logic [2:0] S_VECTOR   = 3'd5;

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic [15:0]        pc_q;
    logic [15:0]        sp_q;
    logic [IDX_W-1:0]   idx_q;
    logic               cancel_q;
    logic [NUM_IRQ-1:0] pend;
    logic               pend_any;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        vec_addr;

    // Priority encode: scanning downwards lets bit 0 win.
    always_comb begin
        pend     = ie_reg & if_reg;
        pend_any = |pend;
        idx      = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign vec_addr = VEC_BASE + 16'(VEC_STEP) * 16'(idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (ime && instr_boundary && pend_any) state_next = S_LATCH_PC;
            S_LATCH_PC: state_next = S_DEC_SP;
            S_DEC_SP:   state_next = S_PUSH_HI;
            S_PUSH_HI:  if (mem_ack) state_next = S_PUSH_LO;
            S_PUSH_LO:  if (mem_ack) state_next = S_VECTOR;
            S_VECTOR:   state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            sp_q     <= '0;
            idx_q    <= '0;
            cancel_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ime && instr_boundary && pend_any) idx_q <= idx;
                end
                S_LATCH_PC: pc_q <= rf_data_rr;
                S_DEC_SP:   sp_q <= rf_data_rr - 16'd1;
                S_PUSH_HI: begin
                    // Re-sample pending set: a late IE clear cancels, a newer higher source wins.
                    if (mem_ack) begin
                        sp_q <= sp_q - 16'd1;
                        if (!pend_any) cancel_q <= 1'b1;
                        else           idx_q    <= idx;
                    end
                end
                S_VECTOR:   cancel_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy            = (state != S_IDLE);
        ime_clear       = 1'b0;
        if_clear        = '0;
        done            = 1'b0;
        rf_read_rr      = 1'b0;
        rf_read_reg_rr  = REG_SP;
        rf_write_rr     = 1'b0;
        rf_write_reg_rr = REG_SP;
        rf_data_in_rr   = '0;
        mem_wr_req      = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        case (state)
            S_LATCH_PC: begin
                ime_clear      = 1'b1;
                rf_read_rr     = 1'b1;
                rf_read_reg_rr = REG_PC;
            end
            S_DEC_SP: begin
                rf_read_rr    = 1'b1;
                rf_write_rr   = 1'b1;
                rf_data_in_rr = rf_data_rr - 16'd1;
            end
            S_PUSH_HI: begin
                mem_wr_req    = 1'b1;
                mem_addr      = sp_q;
                mem_wdata     = pc_q[15:8];
                rf_write_rr   = mem_ack;
                rf_data_in_rr = mem_ack ? (sp_q - 16'd1) : 16'd0;
            end
            S_PUSH_LO: begin
                mem_wr_req = 1'b1;
                mem_addr   = sp_q;
                mem_wdata  = pc_q[7:0];
            end
            S_VECTOR: begin
                done            = 1'b1;
                rf_write_rr     = 1'b1;
                rf_write_reg_rr = REG_PC;
                rf_data_in_rr   = cancel_q ? 16'd0 : vec_addr;
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if_clear[i] = !cancel_q && (idx_q == IDX_W'(i));
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_dispatch_seq.sv
`default_nettype none
// Bench for irq_dispatch_seq: register-file/bus environment plus a transaction-level reference model.

module tb_irq_dispatch_seq;
    import irq_dispatch_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         ime;
    logic         instr_boundary;
    logic [4:0]   ie_reg;
    logic [4:0]   if_reg;
    logic         busy;
    logic         ime_clear;
    logic [4:0]   if_clear;
    logic         done;
    logic         rf_read_rr;
    register_nn_t rf_read_reg_rr;
    logic [15:0]  rf_data_rr;
    logic         rf_write_rr;
    register_nn_t rf_write_reg_rr;
    logic [15:0]  rf_data_in_rr;
    logic         mem_wr_req;
    logic [15:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic         mem_ack;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf_pc;
    logic [15:0] rf_sp;
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    irq_dispatch_seq #(.NUM_IRQ(5), .VEC_BASE(16'h0040), .VEC_STEP(8)) dut (
        .clk(clk), .rst(rst), .ime(ime), .instr_boundary(instr_boundary),
        .ie_reg(ie_reg), .if_reg(if_reg), .busy(busy), .ime_clear(ime_clear),
        .if_clear(if_clear), .done(done), .rf_read_rr(rf_read_rr),
        .rf_read_reg_rr(rf_read_reg_rr), .rf_data_rr(rf_data_rr),
        .rf_write_rr(rf_write_rr), .rf_write_reg_rr(rf_write_reg_rr),
        .rf_data_in_rr(rf_data_in_rr), .mem_wr_req(mem_wr_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    assign rf_data_rr = (rf_read_reg_rr == REG_PC) ? rf_pc :
                        (rf_read_reg_rr == REG_SP) ? rf_sp : 16'h0000;

    always @(posedge clk) begin
        if (rf_write_rr) begin
            if (rf_write_reg_rr == REG_PC) rf_pc <= rf_data_in_rr;
            else if (rf_write_reg_rr == REG_SP) rf_sp <= rf_data_in_rr;
        end
        if (mem_wr_req && mem_ack) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, 32'({busy, ime_clear, if_clear, done, rf_read_rr, rf_write_rr,
                                 rf_data_in_rr, mem_wr_req}), 32'd0);
        check({tag, "_bus"}, {mem_addr, 8'h00, mem_wdata}, 32'd0);
        check({tag, "_sel"}, 32'({rf_read_reg_rr, rf_write_reg_rr}), 32'({REG_SP, REG_SP}));
    endtask

    function automatic int lowest(input logic [4:0] p);
        for (int i = 0; i < 5; i++) if (p[i]) return i;
        return -1;
    endfunction

    // One full dispatch; ie1/if1 are presented from the first PUSH_HI request onwards.
    task automatic dispatch(input logic [15:0] pc0, input logic [15:0] sp0,
                            input logic [4:0] ie0, input logic [4:0] if0,
                            input logic [4:0] ie1, input logic [4:0] if1,
                            input int w_hi, input int w_lo, input bit keep);
        logic [4:0]  pend1;
        logic [15:0] exp_pc;
        logic [4:0]  exp_ifc;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        logic [4:0]  seen_ifc;
        int          n_ic, accepted, waited, done_cyc;
        pend1    = ie1 & if1;
        exp_pc   = (pend1 == 0) ? 16'h0000 : 16'(16'h0040 + 8 * lowest(pend1));
        exp_ifc  = (pend1 == 0) ? 5'd0 : 5'(1 << lowest(pend1));
        n_ic     = 0;
        accepted = 0;
        waited   = 0;
        done_cyc = -1;
        seen_ifc = '0;

        @(negedge clk);
        rf_pc = pc0;
        rf_sp = sp0;
        wr_addr_q.delete();
        wr_data_q.delete();
        ie_reg = ie0;
        if_reg = if0;
        ime = 1'b1;
        instr_boundary = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            ime = 1'($urandom);
            instr_boundary = 1'($urandom);
            check("busy_run", 32'(busy), 32'd1);
            if (ime_clear) n_ic++;
            if (mem_wr_req) begin
                exp_addr = (accepted == 0) ? 16'(sp0 - 16'd1) : 16'(sp0 - 16'd2);
                exp_data = (accepted == 0) ? pc0[15:8] : pc0[7:0];
                check("push_addr", 32'(mem_addr), 32'(exp_addr));
                check("push_data", 32'(mem_wdata), 32'(exp_data));
                if (accepted == 0 && waited == 0) begin
                    ie_reg = ie1;
                    if_reg = if1;
                end
                if (waited == ((accepted == 0) ? w_hi : w_lo)) begin
                    mem_ack = 1'b1;
                    accepted++;
                    waited = 0;
                end else begin
                    mem_ack = 1'b0;
                    waited++;
                end
            end else begin
                mem_ack = 1'($urandom);
            end
            if (done) begin
                done_cyc = cyc;
                seen_ifc = if_clear;
                break;
            end
        end
        mem_ack = 1'b0;
        if (keep) begin
            ime = 1'b1;
            instr_boundary = 1'b1;
            ie_reg = 5'h1F;
            if_reg = 5'h01;
        end else begin
            ime = 1'b0;
            instr_boundary = 1'b0;
        end
        check("done_cycle", 32'(done_cyc), 32'(5 + w_hi + w_lo));
        check("if_clear", 32'(seen_ifc), 32'(exp_ifc));
        check("ime_clear_cnt", 32'(n_ic), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
        check("final_pc", 32'(rf_pc), 32'(exp_pc));
        check("final_sp", 32'(rf_sp), 32'(16'(sp0 - 16'd2)));
        check("wr_count", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check("wr0", {wr_addr_q[0], 8'h00, wr_data_q[0]}, {16'(sp0 - 16'd1), 8'h00, pc0[15:8]});
            check("wr1", {wr_addr_q[1], 8'h00, wr_data_q[1]}, {16'(sp0 - 16'd2), 8'h00, pc0[7:0]});
        end
    endtask

    initial begin
        logic [15:0] rpc, rsp;
        logic [4:0]  rie0, rif0, rie1, rif1;
        int          reached;
        rst = 1'b1;
        ime = 1'b0;
        instr_boundary = 1'b0;
        ie_reg = '0;
        if_reg = '0;
        mem_ack = 1'b0;
        rf_pc = '0;
        rf_sp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        dispatch(16'h1234, 16'hFFFE, 5'h1F, 5'b00100, 5'h1F, 5'b00100, 0, 0, 1'b0);
        dispatch(16'hBEEF, 16'hD000, 5'h1F, 5'b10110, 5'h1F, 5'b10110, 0, 0, 1'b0);
        dispatch(16'h4321, 16'hC100, 5'h1F, 5'b01000, 5'h00, 5'b01000, 1, 0, 1'b0);
        dispatch(16'h0A0B, 16'h8000, 5'h1F, 5'b00010, 5'h1F, 5'b00010, 3, 3, 1'b0);
        dispatch(16'h5678, 16'h0000, 5'h01, 5'b00001, 5'h01, 5'b00001, 0, 0, 1'b0);
        dispatch(16'h9999, 16'hE000, 5'h1F, 5'b10000, 5'h1F, 5'b10001, 2, 1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            rpc  = 16'($urandom);
            rsp  = 16'($urandom);
            rie0 = 5'($urandom_range(1, 31));
            rif0 = 5'($urandom) | (rie0 & (~rie0 + 5'd1));
            case ($urandom_range(0, 3))
                0:       begin rie1 = 5'h00;         rif1 = rif0; end
                1:       begin rie1 = rie0;          rif1 = rif0; end
                default: begin rie1 = 5'($urandom);  rif1 = 5'($urandom); end
            endcase
            dispatch(rpc, rsp, rie0, rif0, rie1, rif1,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end

        dispatch(16'h2222, 16'hA000, 5'h1F, 5'b00100, 5'h1F, 5'b00100, 0, 0, 1'b1);
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_ime_clear", 32'(ime_clear), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_quiet("b2b_reset");

        ie_reg = 5'h1F;
        if_reg = 5'h04;
        ime = 1'b1;
        instr_boundary = 1'b1;
        reached = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            instr_boundary = 1'b0;
            if (mem_wr_req && wr_addr_q.size() > 0) begin
                reached = 1;
                break;
            end
            if (cyc == 0) begin
                wr_addr_q.delete();
                wr_data_q.delete();
            end
            mem_ack = mem_wr_req;
        end
        mem_ack = 1'b0;
        check("reach_push_lo", 32'(reached), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_quiet("mid_reset");

        ime = 1'b0;
        instr_boundary = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            check("idle_no_ime", 32'(busy), 32'd0);
        end
        ime = 1'b1;
        instr_boundary = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            check("idle_no_bnd", 32'(busy), 32'd0);
        end
        instr_boundary = 1'b1;
        ie_reg = 5'h0A;
        if_reg = 5'h15;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            check("idle_no_pend", 32'(busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
